psum_acc: RTL

PSUM_ACC -- requirements
Module: psum_acc

---
 rtl/psum_acc.sv | 105 ++++++++++
 1 files changed

// File: rtl/psum_acc.sv
// Partial-sum accumulator: read-modify-write of a psum buffer,
// two-stage pipeline with same-address forwarding and saturation.
module psum_acc #(
  parameter int PSUM_WIDTH      = 24,
  parameter int PSUM_ADDR_WIDTH = 7
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    datain_val,
  output logic                                    datain_rdy,
  input  logic [PSUM_WIDTH+PSUM_ADDR_WIDTH:0]     datain,
  input  logic                                    fnh_in,
  output logic                                    fnh_out,
  input  logic                                    ram_gnt,
  output logic                                    rd_en,
  output logic [PSUM_ADDR_WIDTH-1:0]              rd_addr,
  input  logic [PSUM_WIDTH-1:0]                   rd_data,
  output logic                                    wr_en,
  output logic [PSUM_ADDR_WIDTH-1:0]              wr_addr,
  output logic [PSUM_WIDTH-1:0]                   wr_data,
  output logic [15:0]                             acc_cnt
);

  localparam int PW = PSUM_WIDTH;
  localparam int AW = PSUM_ADDR_WIDTH;
  localparam logic [PW-1:0] SMAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] SMIN = {1'b1, {(PW-1){1'b0}}};

  typedef struct packed {
    logic          first;
    logic [PW-1:0] psum;
    logic [AW-1:0] addr;
  } tok_t;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  tok_t          in_tok;
  tok_t          s1;
  logic          s1_vld;
  logic          fwd_vld;
  logic          accept;
  logic [PW-1:0] opnd;
  logic [PW:0]   sum_ext;
  logic [PW-1:0] sum_sat;

  assign in_tok     = datain;
  assign datain_rdy = rst_n && (state == RUN) && ram_gnt;
  assign accept     = datain_val && datain_rdy;
  assign rd_en      = accept && !in_tok.first;
  assign rd_addr    = rd_en ? in_tok.addr : '0;
  assign fnh_out    = (state == DONE);

  // The write register doubles as the forwarding source; it holds
  // the newest value of wr_addr until the next write replaces it.
  always_comb begin
    opnd = rd_data;
    if (s1.first)
      opnd = '0;
    else if (fwd_vld && (wr_addr == s1.addr))
      opnd = wr_data;
    sum_ext = {opnd[PW-1], opnd} + {s1.psum[PW-1], s1.psum};
    sum_sat = sum_ext[PW-1:0];
    if (sum_ext[PW] != sum_ext[PW-1])
      sum_sat = sum_ext[PW] ? SMIN : SMAX;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (fnh_in && !accept) state_nxt = DRAIN;
      DRAIN:   if (!s1_vld && !wr_en) state_nxt = DONE;
      DONE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RUN;
      s1_vld  <= 1'b0;
      s1      <= '0;
      fwd_vld <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      acc_cnt <= '0;
    end else begin
      state  <= state_nxt;
      s1_vld <= accept;
      if (accept)
        s1 <= in_tok;
      wr_en <= s1_vld;
      if (s1_vld) begin
        wr_addr <= s1.addr;
        wr_data <= sum_sat;
        fwd_vld <= 1'b1;
      end
      if (wr_en)
        acc_cnt <= acc_cnt + 16'd1;
    end
  end

endmodule
